// File: rtl/thor2021_btb_update.sv
// Thor2021 BTB write-side companion: classifies resolved branches, issues fetch
// redirects on mispredicts and queues BTB install/retarget/invalidate writes.
module thor2021_btb_update #(
    parameter int unsigned AWID  = 64,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            res_v,
    input  logic [AWID-1:0] res_ip,
    input  logic [AWID-1:0] res_nip,
    input  logic            res_takb,
    input  logic [AWID-1:0] res_tgt,
    input  logic            res_pred_hit,
    input  logic [AWID-1:0] res_pred_tgt,
    output logic            res_ready,
    input  logic            btb_busy,
    output logic            btb_wr,
    output logic [AWID-1:0] btb_wip,
    output logic [AWID-1:0] btb_wtgt,
    output logic            btb_takb,
    output logic            redirect_v,
    output logic [AWID-1:0] redirect_ip,
    output logic [CNTW-1:0] mispred_cnt,
    output logic [CNTW-1:0] drop_cnt
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [AWID-1:0] ip;
        logic [AWID-1:0] tgt;
        logic            takb;
    } ent_t;

    ent_t          fifo [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          mispred_c;
    logic          pop_c;
    logic          coal_c;
    logic          enq_c;
    logic          drop_c;
    logic [PW-1:0] last_c;
    ent_t          new_c;

    // Every mispredict needs a BTB write, so "kind != NONE" is exactly mispred_c.
    always_comb begin
        mispred_c  = res_takb ? !(res_pred_hit && (res_pred_tgt == res_tgt)) : res_pred_hit;
        new_c.ip   = res_ip;
        new_c.tgt  = res_takb ? res_tgt : res_pred_tgt;
        new_c.takb = res_takb;
        last_c     = tail - PW'(1);
        pop_c      = (count != '0) && !btb_busy;
        // A lone entry that is draining this cycle cannot be overwritten.
        coal_c     = res_v && mispred_c && (count != '0) && (fifo[last_c].ip == res_ip)
                     && !(pop_c && (count == CW'(1)));
        enq_c      = res_v && mispred_c && !coal_c && res_ready;
        drop_c     = res_v && mispred_c && !coal_c && !res_ready;
    end

    assign res_ready = (count != CW'(DEPTH));
    assign btb_wr    = pop_c;
    assign btb_wip   = fifo[head].ip;
    assign btb_wtgt  = fifo[head].tgt;
    assign btb_takb  = fifo[head].takb;

    // Payload storage; validity is tracked by the pointers/count only.
    always_ff @(posedge clk) begin
        if (coal_c) begin
            fifo[last_c] <= new_c;
        end else if (enq_c) begin
            fifo[tail] <= new_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            redirect_v  <= 1'b0;
            redirect_ip <= '0;
            mispred_cnt <= '0;
            drop_cnt    <= '0;
        end else begin
            if (enq_c) begin
                tail <= tail + PW'(1);
            end
            if (pop_c) begin
                head <= head + PW'(1);
            end
            count      <= count + CW'(enq_c) - CW'(pop_c);
            redirect_v <= res_v && mispred_c;
            if (res_v && mispred_c) begin
                redirect_ip <= res_takb ? res_tgt : res_nip;
                mispred_cnt <= mispred_cnt + CNTW'(1);
            end
            if (drop_c) begin
                drop_cnt <= drop_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_thor2021_btb_update.sv
// Self-checking bench for thor2021_btb_update: queue-based reference model
// updated at each negedge, plus directed checks from the test plan.
module tb_thor2021_btb_update;

    localparam int unsigned AWID  = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNTW  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            res_v;
    logic [AWID-1:0] res_ip, res_nip, res_tgt, res_pred_tgt;
    logic            res_takb, res_pred_hit;
    logic            res_ready;
    logic            btb_busy;
    logic            btb_wr;
    logic [AWID-1:0] btb_wip, btb_wtgt;
    logic            btb_takb;
    logic            redirect_v;
    logic [AWID-1:0] redirect_ip;
    logic [CNTW-1:0] mispred_cnt, drop_cnt;

    thor2021_btb_update #(.AWID(AWID), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst),
        .res_v(res_v), .res_ip(res_ip), .res_nip(res_nip), .res_takb(res_takb),
        .res_tgt(res_tgt), .res_pred_hit(res_pred_hit), .res_pred_tgt(res_pred_tgt),
        .res_ready(res_ready), .btb_busy(btb_busy),
        .btb_wr(btb_wr), .btb_wip(btb_wip), .btb_wtgt(btb_wtgt), .btb_takb(btb_takb),
        .redirect_v(redirect_v), .redirect_ip(redirect_ip),
        .mispred_cnt(mispred_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AWID-1:0] ip;
        logic [AWID-1:0] tgt;
        logic            takb;
    } ent_t;

    int unsigned checks = 0;
    int unsigned errors = 0;

    ent_t            exp_q[$];
    logic            armed = 1'b0;
    logic            exp_rv;
    logic [AWID-1:0] exp_rip;
    logic [CNTW-1:0] exp_mis, exp_drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: check this cycle's outputs, then apply the inputs the next edge sees.
    always @(negedge clk) begin
        logic was_full;
        logic mis;
        ent_t e;
        if (armed) begin
            check("redirect_v", 64'(redirect_v), 64'(exp_rv));
            if (exp_rv) check("redirect_ip", redirect_ip, exp_rip);
            check("mispred_cnt", 64'(mispred_cnt), 64'(exp_mis));
            check("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
            check("res_ready", 64'(res_ready), 64'(exp_q.size() != DEPTH));
            check("btb_wr", 64'(btb_wr), 64'(exp_q.size() != 0 && !btb_busy));
        end
        if (rst) begin
            exp_q.delete();
            exp_rv   = 1'b0;
            exp_rip  = '0;
            exp_mis  = '0;
            exp_drop = '0;
            armed    = 1'b1;
        end else if (armed) begin
            was_full = (exp_q.size() == DEPTH);
            if (exp_q.size() != 0 && !btb_busy) begin
                check("btb_wip", btb_wip, exp_q[0].ip);
                check("btb_wtgt", btb_wtgt, exp_q[0].tgt);
                check("btb_takb", 64'(btb_takb), 64'(exp_q[0].takb));
                void'(exp_q.pop_front());
            end
            mis = res_takb ? !(res_pred_hit && res_pred_tgt == res_tgt) : res_pred_hit;
            exp_rv = res_v && mis;
            if (res_v && mis) begin
                exp_rip = res_takb ? res_tgt : res_nip;
                exp_mis = exp_mis + 1;
                e.ip    = res_ip;
                e.tgt   = res_takb ? res_tgt : res_pred_tgt;
                e.takb  = res_takb;
                if (exp_q.size() != 0 && exp_q[exp_q.size()-1].ip == res_ip)
                    exp_q[exp_q.size()-1] = e;
                else if (!was_full)
                    exp_q.push_back(e);
                else
                    exp_drop = exp_drop + 1;
            end
        end
    end

    task automatic send(input logic [AWID-1:0] ip, input logic [AWID-1:0] nip,
                        input logic takb, input logic [AWID-1:0] tgt,
                        input logic hit, input logic [AWID-1:0] ptgt);
        res_v = 1'b1; res_ip = ip; res_nip = nip; res_takb = takb;
        res_tgt = tgt; res_pred_hit = hit; res_pred_tgt = ptgt;
        @(posedge clk); #1;
        res_v = 1'b0;
    endtask

    task automatic idle(input int n);
        res_v = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        rst = 1'b1; res_v = 1'b0; res_ip = '0; res_nip = '0; res_takb = 1'b0;
        res_tgt = '0; res_pred_hit = 1'b0; res_pred_tgt = '0; btb_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // Install on a cold miss
        send(64'h1000, 64'h1004, 1'b1, 64'h2000, 1'b0, 64'h0);
        check("t1_redirect_v", 64'(redirect_v), 64'd1);
        check("t1_redirect_ip", redirect_ip, 64'h2000);
        check("t1_btb_wr", 64'(btb_wr), 64'd1);
        check("t1_wip", btb_wip, 64'h1000);
        check("t1_wtgt", btb_wtgt, 64'h2000);
        check("t1_takb", 64'(btb_takb), 64'd1);
        check("t1_mispred_cnt", 64'(mispred_cnt), 64'd1);
        idle(1);

        // Correct prediction: nothing happens
        send(64'h1000, 64'h1004, 1'b1, 64'h2000, 1'b1, 64'h2000);
        check("t2_redirect_v", 64'(redirect_v), 64'd0);
        check("t2_btb_wr", 64'(btb_wr), 64'd0);
        check("t2_mispred_cnt", 64'(mispred_cnt), 64'd1);
        idle(1);

        // Not-taken with a hit: invalidate and fall through
        send(64'h1000, 64'h1004, 1'b0, 64'h0, 1'b1, 64'h3000);
        check("t3_redirect_ip", redirect_ip, 64'h1004);
        check("t3_btb_wr", 64'(btb_wr), 64'd1);
        check("t3_takb", 64'(btb_takb), 64'd0);
        check("t3_wip", btb_wip, 64'h1000);
        idle(1);

        // Fill while busy, then drop, then coalesce into a full FIFO
        btb_busy = 1'b1;
        for (int i = 1; i <= 4; i++)
            send(64'(i) << 8, (64'(i) << 8) + 4, 1'b1, (64'(i) << 8) + 64'h10, 1'b0, 64'h0);
        check("t4_res_ready", 64'(res_ready), 64'd0);
        send(64'h500, 64'h504, 1'b1, 64'h510, 1'b0, 64'h0);
        check("t4_drop_cnt", 64'(drop_cnt), 64'd1);
        send(64'h400, 64'h404, 1'b1, 64'h999, 1'b0, 64'h0);
        check("t4_drop_cnt_coal", 64'(drop_cnt), 64'd1);
        btb_busy = 1'b0;
        idle(6);

        // Back-to-back same ip while busy coalesces into one entry
        btb_busy = 1'b1;
        send(64'h100, 64'h104, 1'b1, 64'h10, 1'b0, 64'h0);
        send(64'h100, 64'h104, 1'b1, 64'h20, 1'b0, 64'h0);
        check("t5_wtgt", btb_wtgt, 64'h20);
        btb_busy = 1'b0;
        idle(3);

        // Same ip while the lone entry drains: enqueued, not coalesced
        send(64'h700, 64'h704, 1'b1, 64'h70, 1'b0, 64'h0);
        send(64'h700, 64'h704, 1'b1, 64'h71, 1'b0, 64'h0);
        check("t6_btb_wr", 64'(btb_wr), 64'd1);
        check("t6_wtgt", btb_wtgt, 64'h71);
        idle(3);

        // Reset mid-drain with a redirect pending
        btb_busy = 1'b1;
        for (int i = 1; i <= 3; i++)
            send(64'h800 + (64'(i) << 4), 64'h0, 1'b1, 64'h900, 1'b0, 64'h0);
        check("t7_redirect_v_pre", 64'(redirect_v), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t7_redirect_v", 64'(redirect_v), 64'd0);
        check("t7_mispred_cnt", 64'(mispred_cnt), 64'd0);
        check("t7_drop_cnt", 64'(drop_cnt), 64'd0);
        check("t7_res_ready", 64'(res_ready), 64'd1);
        btb_busy = 1'b0;
        idle(1);
        check("t7_btb_wr", 64'(btb_wr), 64'd0);

        // Random traffic over a small address set to exercise coalescing and drops
        for (int n = 0; n < 300; n++) begin
            btb_busy     = ($urandom_range(0, 3) == 0) ? 1'b0 : ($urandom_range(0, 1) == 1);
            res_v        = ($urandom_range(0, 2) != 0);
            res_ip       = 64'h100 * 64'($urandom_range(1, 5));
            res_nip      = res_ip + 64'h4;
            res_takb     = $urandom_range(0, 1) == 1;
            res_tgt      = 64'h40 * 64'($urandom_range(1, 3));
            res_pred_hit = $urandom_range(0, 1) == 1;
            res_pred_tgt = 64'h40 * 64'($urandom_range(1, 3));
            @(posedge clk); #1;
        end
        res_v = 1'b0; btb_busy = 1'b0;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
